// File: rtl/seg_letter_scan_ctrl_if.sv
// Letter push channel between the cipher core and the display scan controller.
// The clear strobe travels with the push so that the two can be arbitrated in one place.
interface seg_letter_scan_ctrl_if;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] letter_in;
   logic       clear;

   modport master (
      output in_valid,
      output letter_in,
      output clear,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  letter_in,
      input  clear,
      output in_ready
   );
endinterface

// File: rtl/seg_letter_scan_ctrl.sv
// Multiplexed scan controller for an 8-digit seven-segment letter display.
// Letters shift in from the right; each digit slot opens with a guard interval of dark anodes.
module seg_letter_scan_ctrl #(
   parameter int NUM_DIGITS   = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int GUARD_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   seg_letter_scan_ctrl_if.slave bus,
   output logic [5:0]            letter_code,
   output logic                  digit_blank,
   output logic [NUM_DIGITS-1:0] an,
   output logic [2:0]            scan_idx,
   output logic [3:0]            letters_shown
);

   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
   localparam logic [DIV_W-1:0] GUARD_END = DIV_W'(GUARD_CYCLES);
   localparam logic [2:0]       SCAN_LAST = 3'(NUM_DIGITS - 1);
   localparam logic [3:0]       SHOWN_MAX = 4'(NUM_DIGITS);

   logic [DIV_W-1:0]           div_cnt_q, div_cnt_d;
   logic [2:0]                 scan_idx_q, scan_idx_d;
   logic [3:0]                 shown_q, shown_d;
   logic [NUM_DIGITS-1:0][5:0] code_q, code_d;
   logic [NUM_DIGITS-1:0]      valid_q, valid_d;
   logic [NUM_DIGITS-1:0]      an_q, an_d;
   logic [5:0]                 letter_code_q, letter_code_d;
   logic                       blank_q, blank_d;

   logic       push;
   logic       show;
   logic       cur_valid;
   logic [5:0] cur_code;

   // Clear has priority over a push presented in the same cycle.
   assign bus.in_ready = ~bus.clear;
   assign push         = bus.in_valid & bus.in_ready;

   always_comb begin
      code_d        = code_q;
      valid_d       = valid_q;
      shown_d       = shown_q;
      div_cnt_d     = div_cnt_q;
      scan_idx_d    = scan_idx_q;
      cur_code      = '0;
      cur_valid     = 1'b0;
      an_d          = '1;

      if (bus.clear) begin
         code_d  = '0;
         valid_d = '0;
         shown_d = '0;
      end else if (push) begin
         for (int i = 1; i < NUM_DIGITS; i++) begin
            code_d[i]  = code_q[i-1];
            valid_d[i] = valid_q[i-1];
         end
         code_d[0]  = bus.letter_in;
         valid_d[0] = (bus.letter_in <= 6'd25);
         shown_d    = (shown_q == SHOWN_MAX) ? shown_q : shown_q + 4'd1;
      end

      if (div_cnt_q == DIV_LAST) begin
         div_cnt_d  = '0;
         scan_idx_d = (scan_idx_q == SCAN_LAST) ? 3'd0 : scan_idx_q + 3'd1;
      end else begin
         div_cnt_d  = div_cnt_q + DIV_W'(1);
      end

      // Mux by comparison rather than indexing so narrow displays never see an out-of-range index.
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (scan_idx_q == 3'(i)) begin
            cur_code  = code_q[i];
            cur_valid = valid_q[i];
         end
      end

      show = (div_cnt_q >= GUARD_END) & cur_valid;

      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (show && (scan_idx_q == 3'(i))) begin
            an_d[i] = 1'b0;
         end
      end

      letter_code_d = cur_code;
      blank_d       = ~show;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q     <= '0;
         scan_idx_q    <= '0;
         shown_q       <= '0;
         code_q        <= '0;
         valid_q       <= '0;
         an_q          <= '1;
         letter_code_q <= '0;
         blank_q       <= 1'b1;
      end else begin
         div_cnt_q     <= div_cnt_d;
         scan_idx_q    <= scan_idx_d;
         shown_q       <= shown_d;
         code_q        <= code_d;
         valid_q       <= valid_d;
         an_q          <= an_d;
         letter_code_q <= letter_code_d;
         blank_q       <= blank_d;
      end
   end

   assign an            = an_q;
   assign letter_code   = letter_code_q;
   assign digit_blank   = blank_q;
   assign scan_idx      = scan_idx_q;
   assign letters_shown = shown_q;

endmodule

// File: tb/tb_seg_letter_scan_ctrl.sv
// Directed bench for seg_letter_scan_ctrl with a short refresh period (8 cycles, 2 guard cycles).
// A small buffer model plus a cycle counter from reset release give the expected scan outputs.
module tb_seg_letter_scan_ctrl;

   localparam int NUM_DIGITS   = 8;
   localparam int REFRESH_DIV  = 8;
   localparam int GUARD_CYCLES = 2;
   localparam int FRAME        = NUM_DIGITS * REFRESH_DIV;

   logic       clk;
   logic       rst_n;
   logic [5:0] letter_code;
   logic       digit_blank;
   logic [7:0] an;
   logic [2:0] scan_idx;
   logic [3:0] letters_shown;

   seg_letter_scan_ctrl_if bus ();

   seg_letter_scan_ctrl #(
      .NUM_DIGITS   (NUM_DIGITS),
      .REFRESH_DIV  (REFRESH_DIV),
      .GUARD_CYCLES (GUARD_CYCLES)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus.slave),
      .letter_code   (letter_code),
      .digit_blank   (digit_blank),
      .an            (an),
      .scan_idx      (scan_idx),
      .letters_shown (letters_shown)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         tests = 0;
   int         fails = 0;
   int         cyc   = 0;
   bit         exp_valid [NUM_DIGITS];
   logic [5:0] exp_code  [NUM_DIGITS];
   int         exp_shown = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock edge, then settle before anything is sampled or driven.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic applyStimulus(input logic valid, input logic [5:0] letter, input logic clr);
      bus.in_valid  = valid;
      bus.letter_in = letter;
      bus.clear     = clr;
   endtask

   task automatic modelClear();
      for (int i = 0; i < NUM_DIGITS; i++) begin
         exp_valid[i] = 1'b0;
         exp_code[i]  = 6'd0;
      end
      exp_shown = 0;
   endtask

   task automatic pushLetter(input logic [5:0] letter);
      applyStimulus(1'b1, letter, 1'b0);
      #1;
      checkOutput("push_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      applyStimulus(1'b0, 6'd0, 1'b0);
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         exp_valid[i] = exp_valid[i-1];
         exp_code[i]  = exp_code[i-1];
      end
      exp_code[0]  = letter;
      exp_valid[0] = (letter <= 6'd25);
      exp_shown    = (exp_shown == NUM_DIGITS) ? NUM_DIGITS : exp_shown + 1;
   endtask

   task automatic clearBuffer();
      applyStimulus(1'b0, 6'd0, 1'b1);
      tick();
      applyStimulus(1'b0, 6'd0, 1'b0);
      modelClear();
   endtask

   // Runs one whole display frame and checks every registered output on every cycle.
   task automatic scanFrame(input string tag);
      int lowCnt = 0;
      int expLow = 0;
      for (int k = 0; k < FRAME; k++) begin
         int         div  = cyc % REFRESH_DIV;
         int         slot = (cyc / REFRESH_DIV) % NUM_DIGITS;
         bit         show = (div >= GUARD_CYCLES) && exp_valid[slot];
         logic [7:0] expAn = 8'hFF;
         logic [5:0] expCode = exp_code[slot];
         if (show) expAn[slot] = 1'b0;
         tick();
         checkOutput({tag, "_an"}, 32'(an), 32'(expAn));
         checkOutput({tag, "_blank"}, 32'(digit_blank), 32'(!show));
         checkOutput({tag, "_code"}, 32'(letter_code), 32'(expCode));
         checkOutput({tag, "_scan_idx"}, 32'(scan_idx), 32'((cyc / REFRESH_DIV) % NUM_DIGITS));
         if (show) expLow++;
         if (an !== 8'hFF) lowCnt++;
      end
      checkOutput({tag, "_low_cycles"}, 32'(lowCnt), 32'(expLow));
      checkOutput({tag, "_shown"}, 32'(letters_shown), 32'(exp_shown));
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 6'd0, 1'b0);
      modelClear();
      repeat (2) @(posedge clk);
      #1;

      checkOutput("rst_an", 32'(an), 32'hFF);
      checkOutput("rst_blank", 32'(digit_blank), 32'd1);
      checkOutput("rst_code", 32'(letter_code), 32'd0);
      checkOutput("rst_shown", 32'(letters_shown), 32'd0);
      checkOutput("rst_scan_idx", 32'(scan_idx), 32'd0);
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

      rst_n = 1'b1;
      cyc   = 0;
      scanFrame("idle");

      // A then B: B lands on slot 0, A on slot 1.
      pushLetter(6'd0);
      pushLetter(6'd1);
      checkOutput("ab_shown", 32'(letters_shown), 32'd2);
      scanFrame("ab");

      // Out-of-range code counts but stays dark.
      clearBuffer();
      checkOutput("clr1_shown", 32'(letters_shown), 32'd0);
      pushLetter(6'd30);
      checkOutput("blank_shown", 32'(letters_shown), 32'd1);
      scanFrame("blank30");

      // Nine pushes overflow the buffer; code 0 falls off the left end.
      clearBuffer();
      for (int v = 0; v < 9; v++) pushLetter(6'(v));
      checkOutput("sat_shown", 32'(letters_shown), 32'd8);
      scanFrame("sat");

      // Clear arriving with a push drops the push.
      clearBuffer();
      for (int v = 10; v < 15; v++) pushLetter(6'(v));
      checkOutput("five_shown", 32'(letters_shown), 32'd5);
      applyStimulus(1'b1, 6'd7, 1'b1);
      #1;
      checkOutput("clash_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      applyStimulus(1'b0, 6'd0, 1'b0);
      modelClear();
      checkOutput("clash_shown", 32'(letters_shown), 32'd0);
      scanFrame("clash");

      // Asynchronous reset in the active part of slot 3.
      for (int v = 20; v < 24; v++) pushLetter(6'(v));
      for (int k = 0; k < FRAME && ((cyc - 1) % FRAME) != (3 * REFRESH_DIV + 4); k++) tick();
      checkOutput("pre_rst_an", 32'(an), 32'hF7);
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_an", 32'(an), 32'hFF);
      checkOutput("async_rst_blank", 32'(digit_blank), 32'd1);
      checkOutput("async_rst_scan_idx", 32'(scan_idx), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
      modelClear();
      pushLetter(6'd2);
      scanFrame("post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seg_letter_scan_ctrl.md
Name: seg_letter_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit seven-segment display that shows Enigma output letters. It accepts letter codes (0=A … 25=Z) from the cipher core through a valid/ready handshake and holds them in a shift buffer, newest letter on the rightmost digit. It cycles through the digits, presenting one 6-bit letter code per slot to the combinational letter-to-segment decoder and driving the active-low anodes. Each slot starts with a guard interval to suppress ghosting.

Parameters:
NUM_DIGITS, 8, number of display digits; legal range 2..8.
REFRESH_DIV, 100000, clock cycles per digit slot; must be greater than GUARD_CYCLES.
GUARD_CYCLES, 16, cycles at the start of each slot with all anodes off; must be at least 1.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  letter_in is presented this cycle.
in_ready  out  1  controller accepts a letter; equals ~clear (combinational).
letter_in  in  6  letter code; 0..25 is valid, 26..63 is stored as a blank digit.
clear  in  1  single-cycle synchronous blank of the whole buffer.
letter_code  out  6  registered code of the digit currently being scanned; drives the decoder.
digit_blank  out  1  registered; 1 when the current slot shows nothing (guard interval or blank digit).
an  out  NUM_DIGITS  registered active-low anode enables.
scan_idx  out  3  current digit slot index, 0 = rightmost.
letters_shown  out  4  count of pushes since reset or clear, saturating at NUM_DIGITS.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Every buffer entry: code 0, valid flag 0.
  - div_cnt=0, scan_idx=0, letters_shown=0.
  - an = all ones, letter_code=0, digit_blank=1.
- Push (accepted when in_valid & in_ready):
  - Shift buffer: entry[i] <= entry[i-1] for i ≥ 1; entry[0] <= {letter_in, letter_in<=25}.
  - The entry in position NUM_DIGITS-1 is discarded.
  - letters_shown increments and saturates at NUM_DIGITS. Invalid codes still count.
- Clear:
  - At the next edge, all valid flags go to 0, codes go to 0, letters_shown goes to 0.
  - The scan counters are unaffected.
  - If clear and in_valid are high in the same cycle, clear wins: in_ready=0 and the letter is dropped.
- Scan counter:
  - div_cnt counts 0..REFRESH_DIV-1.
  - On wrap, div_cnt goes to 0 and scan_idx goes to (scan_idx+1) mod NUM_DIGITS (NUM_DIGITS-1 wraps to 0).
  - The counter free-runs and is independent of pushes.
- Registered outputs, computed every edge from pre-edge state:
  - show = (div_cnt >= GUARD_CYCLES) & valid[scan_idx].
  - an <= show ? all ones with bit scan_idx cleared : all ones.
  - digit_blank <= ~show.
  - letter_code <= code[scan_idx] (updated even while blank).
  - Exactly one anode bit may be low at any time; all high during guard cycles.
- Latency:
  - A pushed letter affects an and letter_code at the second edge after acceptance: one edge to write the buffer, one to register the output, provided its digit is being scanned.
- Timing boundary cases:
  - A push during the active slot of the affected digit takes effect mid-slot; this is acceptable.
  - A clear during the active part of a slot turns that anode off at the second edge after clear.
- Reset mid-slot: an returns to all ones immediately (asynchronously); scanning restarts at slot 0, cycle 0.

Test Plan:
- Reset → an=8'hFF, digit_blank=1, letter_code=0, letters_shown=0, in_ready=1; then run a full 8×REFRESH_DIV period → an stays 8'hFF.
- With REFRESH_DIV=8, GUARD_CYCLES=2, push 0 (A) then 1 (B):
  - Slot 0: an=8'hFE, letter_code=1 for div_cnt 2..7 (anode low 6 cycles per slot).
  - Slot 1: an=8'hFD, letter_code=0.
  - Slots 2..7 keep an=8'hFF.
- Push 30 → letters_shown=1, digit 0 remains blank (an=8'hFF in slot 0, digit_blank=1).
- Push codes 0..8 (9 pushes) → letters_shown=8.
  - Slot 7 shows code 1; slot 0 shows code 8.
  - Code 0 is gone.
- Push 5 letters, then assert clear together with in_valid (letter_in=7):
  - in_ready=0 that cycle.
  - letters_shown=0 afterwards.
  - All slots blank; code 7 never appears.
- Assert rst_n=0 mid-slot 3 while an=8'hF7 → an=8'hFF in the same cycle.
  - After release, the first active anode is 8'hFE, provided its digit is valid, at div_cnt=GUARD_CYCLES.
